// File: rtl/counter_pkg.sv
// counter_pkg: shared state encoding and default widths for the down counter/timer.
package counter_pkg;
    localparam int WIDTH_DEF      = 16;
    localparam int PRESCALE_W_DEF = 8;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: free-running divider that ticks when its count matches prescale, then restarts.
module counter_prescaler #(
    parameter int W = counter_pkg::PRESCALE_W_DEF
) (
    input  logic         clock0,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_en,
    input  logic [W-1:0] i_prescale,
    output logic         o_tick
);
    logic [W-1:0] r_cnt;
    assign o_tick = i_en && (r_cnt == i_prescale);
    // a prescale lowered below r_cnt simply lets r_cnt run on and wrap
    always_ff @(negedge clock0) begin
        if (reset || i_clear)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= o_tick ? '0 : r_cnt + W'(1);
    end
endmodule

// File: rtl/counterdown16_load_1clk_negedge_sync_resetp.sv
// counterdown16_load_1clk_negedge_sync_resetp: loadable down timer with prescaler and terminal-count pulse.
// Define COUNTERDOWN_AUTORELOAD_EN to reload from the reload register at terminal count and keep running.
module counterdown16_load_1clk_negedge_sync_resetp
    import counter_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  clock0,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  start,
    input  logic                  stop,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  tc,
    output logic                  done
);
    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_count, w_count_nx, r_reload, w_reload_nx;
    logic             r_tc, w_tc_nx, r_done, w_done_nx;
    logic             w_run, w_clr, w_tick;

    assign w_run = (r_state == RUN);
    // prescaler restarts on every control event that changes the run state
    assign w_clr = load || (w_run ? stop : start);

    counter_prescaler #(.W(PRESCALE_W)) u_pre (
        .clock0     (clock0),
        .reset      (reset),
        .i_clear    (w_clr),
        .i_en       (w_run),
        .i_prescale (prescale),
        .o_tick     (w_tick)
    );

    always_ff @(negedge clock0) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_count  <= w_count_nx;
            r_reload <= w_reload_nx;
            r_tc     <= w_tc_nx;
            r_done   <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_count_nx  = r_count;
        w_reload_nx = r_reload;
        w_tc_nx     = 1'b0;
        w_done_nx   = r_done;
        if (load) begin
            w_state_nx  = IDLE;
            w_count_nx  = load_value;
            w_reload_nx = load_value;
            w_done_nx   = 1'b0;
        end else if (w_run && stop) begin
            w_state_nx = IDLE;
        end else if (!w_run && start) begin
            w_state_nx = (r_count != '0) ? RUN : DONE;
            w_done_nx  = (r_count == '0);
            w_tc_nx    = (r_count == '0);
        end else if (w_tick) begin
            if (r_count == WIDTH'(1)) begin
                w_tc_nx = 1'b1;
`ifdef COUNTERDOWN_AUTORELOAD_EN
                w_count_nx = r_reload;
`else
                w_count_nx = '0;
                w_state_nx = DONE;
                w_done_nx  = 1'b1;
`endif
            end else begin
                w_count_nx = r_count - WIDTH'(1);
            end
        end
    end

    assign count = r_count;
    assign busy  = w_run;
    assign tc    = r_tc;
    assign done  = r_done;
endmodule

// File: doc/counterdown16_load_1clk_negedge_sync_resetp.md
# counterdown16_load_1clk_negedge_sync_resetp

Loadable 16-bit down counter/timer with programmable prescaler, start/stop control and terminal-count signalling. It is the counting-down counterpart of the team's negedge up counters: software-style load of a value, count to zero, flag completion. All state updates on the falling edge of `clock0`. It serves as a simple interval timer in the simple_registers benchmark set.

## Interface
- `WIDTH`, 16, counter width.
- `PRESCALE_W`, 8, prescaler width.

- `clock0`  in  1  clock; all state changes on negedge.
- `reset`  in  1  reset, synchronous, active-high.
- `load`  in  1  load `load_value` into count and reload register.
- `load_value`  in  WIDTH  value to load.
- `start`  in  1  begin/resume counting.
- `stop`  in  1  pause counting.
- `prescale`  in  PRESCALE_W  decrement every `prescale`+1 clocks; sampled each cycle.
- `count`  out  WIDTH  current count.
- `busy`  out  1  high while state is RUN.
- `tc`  out  1  one-cycle terminal-count pulse.
- `done`  out  1  sticky completion flag.

## Operation
- States: IDLE (reset/paused), RUN, DONE.
- Priority each edge: reset > load > stop > start > tick.
- Reset: count=0, reload=0, prescaler=0, busy=0, tc=0, done=0, state IDLE.
- load (any state): count<=load_value, reload<=load_value, prescaler<=0, done<=0, tc<=0, state IDLE.
- start in IDLE or DONE: count≠0 -> RUN, prescaler<=0, done<=0; count==0 -> DONE, done<=1, tc<=1 for one cycle.
- start in RUN: ignored.
- stop in RUN: state IDLE, count held, prescaler<=0; later start resumes from held count. stop outside RUN: no effect.
- RUN: prescaler increments each edge; when prescaler==prescale, tick: prescaler<=0, count<=count-1.
- Tick with count==1: tc<=1; count<=0, state DONE, done<=1.
- tc is high exactly one cycle per terminal event; otherwise 0.
- No wrap-around: count never decrements below 0.

## Timing
- start sampled at negedge N -> busy=1 after N.
- prescale=0: first decrement at N+1, count reaches 0 at N+V for loaded value V; tc and done high after N+V, busy low after N+V.
- General: decrement every prescale+1 edges; terminal at N+V*(prescale+1).
- tc registered; asserted in same cycle that count shows 0 (or the reload value).
- Changing `prescale` mid-count takes effect on the next comparison; if the new value is below the current prescaler, the prescaler keeps counting and wraps at 2^PRESCALE_W.
- load/reset during RUN abort immediately; no tc generated.

## Configuration
- `COUNTERDOWN_AUTORELOAD_EN`: when defined, tick with count==1 pulses tc, sets count<=reload, stays RUN; done is never set from RUN, only by start with count==0. reload==1 gives tc on every tick. Without macro: one-shot behaviour above.

## Structure
- Package `counter_pkg`: state enum (IDLE, RUN, DONE), default WIDTH/PRESCALE_W constants.
- Sub-module `counter_prescaler`: PRESCALE_W counter with clear input and tick output; top holds FSM, count and reload registers.

## Test plan
- Reset mid-RUN with count=5 -> next cycle count=0, busy=0, tc=0, done=0.
- load 3, start, prescale=0 -> count 3,2,1,0 on consecutive negedges; tc one cycle with count=0; done=1; busy=0.
- load 2, prescale=3, start -> decrements every 4 edges; tc 8 edges after start.
- load 10, start, stop after 4 edges, wait 5, start -> count holds 6 while paused, resumes to 0 with one tc.
- start with count=0 -> done=1, tc single pulse, busy stays 0; load and start in same cycle -> load wins, state IDLE.
- With COUNTERDOWN_AUTORELOAD_EN: load 3, start -> tc every 3 edges, count sequence 3,2,1,3,2,1, done=0, busy=1.
